// File: rtl/tri_512x162_4w_arb_pkg.sv
// Shared types and constants for the 512x162 4-way tag array arbiter.
package tri_512x162_4w_arb_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int RD_LAT = 2;
  localparam int TAG_W  = 4;
endpackage

// File: rtl/tri_512x162_4w_arb_if.sv
// Request/response and array-side bundle between requesters and the arbiter.
interface tri_512x162_4w_arb_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 162,
  parameter int WAYS   = 4
) ();
  logic                                 init_req;
  logic                                 init_busy;
  logic                                 wr_val;
  logic                                 wr_rdy;
  logic [ADDR_W-1:0]                    wr_addr;
  logic [WAYS-1:0]                      wr_way;
  logic [DATA_W-1:0]                    wr_data;
  logic                                 rd_val;
  logic                                 rd_rdy;
  logic [ADDR_W-1:0]                    rd_addr;
  logic [tri_512x162_4w_arb_pkg::TAG_W-1:0] rd_tag;
  logic                                 rsp_val;
  logic [tri_512x162_4w_arb_pkg::TAG_W-1:0] rsp_tag;
  logic [1:0]                           ary_read_act;
  logic                                 ary_write_enable;
  logic [WAYS-1:0]                      ary_write_way;
  logic [ADDR_W-1:0]                    ary_addr;
  logic [DATA_W-1:0]                    ary_data_in;

  modport master (
    output init_req, wr_val, wr_addr, wr_way, wr_data, rd_val, rd_addr, rd_tag,
    input  init_busy, wr_rdy, rd_rdy, rsp_val, rsp_tag,
           ary_read_act, ary_write_enable, ary_write_way, ary_addr, ary_data_in
  );
  modport slave (
    input  init_req, wr_val, wr_addr, wr_way, wr_data, rd_val, rd_addr, rd_tag,
    output init_busy, wr_rdy, rd_rdy, rsp_val, rsp_tag,
           ary_read_act, ary_write_enable, ary_write_way, ary_addr, ary_data_in
  );
endinterface

// File: rtl/tri_512x162_4w_arb_rsp_pipe.sv
// Valid/tag delay line that tracks reads through the RAM stage and data_out latch.
module tri_512x162_4w_rsp_pipe
  import tri_512x162_4w_arb_pkg::*;
(
  input  logic             nclk,
  input  logic             rst_b,
  input  logic             in_val,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_val,
  output logic [TAG_W-1:0] out_tag
);
  logic [RD_LAT:1]            vld_pipe;
  logic [RD_LAT:1][TAG_W-1:0] tag_pipe;

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_val;
      tag_pipe[1] <= in_tag;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign out_val = vld_pipe[RD_LAT];
  assign out_tag = tag_pipe[RD_LAT];
endmodule

// File: rtl/tri_512x162_4w_arb.sv
// Single-port tag array arbiter: power-on/requested clear sweep, then write-over-read
// arbitration with a starvation escape for reads.
module tri_512x162_4w_arb
  import tri_512x162_4w_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 162,
  parameter int WAYS       = 4,
  parameter int STARVE_MAX = 4
) (
  input logic                 nclk,
  input logic                 rst_b,
  tri_512x162_4w_arb_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [SW-1:0]     starve, starve_nx;
  logic              run, rd_win, wr_gnt, rd_gnt;

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= ST_INIT;
      cnt    <= '0;
      starve <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      starve <= starve_nx;
    end
  end

  // Ready depends only on the other port's valid, never on its own.
  assign run         = (state == ST_RUN);
  assign rd_win      = (starve == SMAX);
  assign bus.wr_rdy  = run & ~(bus.rd_val & rd_win);
  assign bus.rd_rdy  = run & (~bus.wr_val | rd_win);
  assign wr_gnt      = bus.wr_val & bus.wr_rdy;
  assign rd_gnt      = bus.rd_val & bus.rd_rdy;
  assign bus.init_busy = ~run;

  always_comb begin
    state_nx             = state;
    cnt_nx               = cnt;
    bus.ary_read_act     = 2'b00;
    bus.ary_write_enable = 1'b0;
    bus.ary_write_way    = '0;
    bus.ary_addr         = '0;
    bus.ary_data_in      = '0;
    case (state)
      ST_INIT: begin
        bus.ary_write_enable = rst_b;
        bus.ary_write_way    = '1;
        bus.ary_addr         = cnt;
        cnt_nx               = cnt + 1'b1;
        if (cnt == '1) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (bus.init_req) begin
          state_nx = ST_INIT;
          cnt_nx   = '0;
        end
        if (wr_gnt) begin
          bus.ary_write_enable = 1'b1;
          bus.ary_write_way    = bus.wr_way;
          bus.ary_addr         = bus.wr_addr;
          bus.ary_data_in      = bus.wr_data;
        end else if (rd_gnt) begin
          bus.ary_read_act = 2'b11;
          bus.ary_addr     = bus.rd_addr;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_comb begin
    starve_nx = '0;
    if (bus.rd_val && !rd_gnt) starve_nx = rd_win ? starve : starve + 1'b1;
  end

  tri_512x162_4w_rsp_pipe u_rsp_pipe (
    .nclk    (nclk),
    .rst_b   (rst_b),
    .in_val  (rd_gnt),
    .in_tag  (bus.rd_tag),
    .out_val (bus.rsp_val),
    .out_tag (bus.rsp_tag)
  );
endmodule

// File: tb/tb_tri_512x162_4w_arb.sv
// Directed bench for the tag array arbiter, with a behavioural array model behind it.
module tb_tri_512x162_4w_arb;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 162;
  localparam int WAYS   = 4;

  logic nclk;
  logic rst_b;
  int   n_vec;
  int   n_err;

  tri_512x162_4w_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS)) bus ();

  tri_512x162_4w_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .STARVE_MAX(4)) dut (
    .nclk  (nclk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  // Array model: RAM read stage then data_out latch.
  logic [DATA_W-1:0] mem  [2**ADDR_W][WAYS];
  logic [DATA_W-1:0] rd_q [WAYS];
  logic [DATA_W-1:0] dout [WAYS];
  always @(posedge nclk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (bus.ary_write_enable && bus.ary_write_way[w]) mem[bus.ary_addr][w] <= bus.ary_data_in;
      if (bus.ary_read_act == 2'b11) rd_q[w] <= mem[bus.ary_addr][w];
      dout[w] <= rd_q[w];
    end
  end

  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] zero;

  task automatic tick();
    @(posedge nclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.init_req = 1'b0;
    bus.wr_val   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_way   = '0;
    bus.wr_data  = '0;
    bus.rd_val   = 1'b0;
    bus.rd_addr  = '0;
    bus.rd_tag   = '0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    idle_inputs();
    bus.wr_val = 1'b1;
    bus.rd_val = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({bus.wr_rdy, bus.rd_rdy, bus.ary_read_act, bus.ary_write_enable, bus.init_busy, bus.rsp_val} !== 7'b0000010) begin
        n_err++;
        $display("FAIL reset_outputs: got %b want 0000010",
                 {bus.wr_rdy, bus.rd_rdy, bus.ary_read_act, bus.ary_write_enable, bus.init_busy, bus.rsp_val});
      end
      n_vec++;
      if (bus.rsp_tag !== 4'h0) begin
        n_err++;
        $display("FAIL reset_tag: got %h want 0", bus.rsp_tag);
      end
      tick();
    end
    idle_inputs();
    rst_b = 1'b1;
  endtask

  task automatic test_init_sweep();
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      #1;
      n_vec++;
      if (bus.init_busy !== 1'b1 || bus.ary_write_enable !== 1'b1 || bus.ary_write_way !== 4'b1111 ||
          bus.ary_addr !== ADDR_W'(i) || bus.ary_data_in !== zero || bus.rd_rdy !== 1'b0) begin
        n_err++;
        if (bad < 4)
          $display("FAIL sweep_step: cycle %0d got busy=%b we=%b way=%b addr=%0d want busy=1 we=1 way=1111 addr=%0d",
                   i, bus.init_busy, bus.ary_write_enable, bus.ary_write_way, bus.ary_addr, i);
        bad++;
      end
      tick();
    end
    #1;
    n_vec++;
    if (bus.init_busy !== 1'b0 || bus.rd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_done: got busy=%b rd_rdy=%b want busy=0 rd_rdy=1", bus.init_busy, bus.rd_rdy);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    bus.wr_val = 1'b1; bus.wr_addr = 9'd5; bus.wr_way = 4'b0010; bus.wr_data = ones;
    #1;
    n_vec++;
    if (bus.wr_rdy !== 1'b1 || bus.ary_write_enable !== 1'b1 || bus.ary_write_way !== 4'b0010 ||
        bus.ary_addr !== 9'd5 || bus.ary_read_act !== 2'b00) begin
      n_err++;
      $display("FAIL wr_grant: got rdy=%b we=%b way=%b addr=%0d act=%b want 1 1 0010 5 00",
               bus.wr_rdy, bus.ary_write_enable, bus.ary_write_way, bus.ary_addr, bus.ary_read_act);
    end
    tick();
    idle_inputs();
    bus.rd_val = 1'b1; bus.rd_addr = 9'd5; bus.rd_tag = 4'd3;
    #1;
    n_vec++;
    if (bus.rd_rdy !== 1'b1 || bus.ary_read_act !== 2'b11 || bus.ary_addr !== 9'd5 || bus.ary_write_enable !== 1'b0) begin
      n_err++;
      $display("FAIL rd_grant: got rdy=%b act=%b addr=%0d we=%b want 1 11 5 0",
               bus.rd_rdy, bus.ary_read_act, bus.ary_addr, bus.ary_write_enable);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (bus.rsp_val !== 1'b0) begin
      n_err++;
      $display("FAIL rsp_early: got rsp_val=%b want 0", bus.rsp_val);
    end
    tick();
    n_vec++;
    if (bus.rsp_val !== 1'b1 || bus.rsp_tag !== 4'd3) begin
      n_err++;
      $display("FAIL rsp_wr_rd: got val=%b tag=%0d want val=1 tag=3", bus.rsp_val, bus.rsp_tag);
    end
    n_vec++;
    if (dout[1] !== ones || dout[0] !== zero) begin
      n_err++;
      $display("FAIL rsp_data: got way1=%h way0=%h want way1 all ones way0 zero", dout[1], dout[0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_rd;
    idle_inputs();
    bus.wr_val = 1'b1; bus.wr_addr = 9'd10; bus.wr_way = 4'b0001; bus.wr_data = DATA_W'(5);
    bus.rd_val = 1'b1; bus.rd_addr = 9'd11; bus.rd_tag = 4'd7;
    for (int k = 0; k < 15; k++) begin
      exp_rd = ((k % 5) == 4);
      #1;
      n_vec++;
      if (bus.rd_rdy !== exp_rd || bus.wr_rdy !== !exp_rd ||
          bus.ary_read_act !== {2{exp_rd}} || bus.ary_write_enable !== !exp_rd) begin
        n_err++;
        $display("FAIL starve_pattern: cycle %0d got wr_rdy=%b rd_rdy=%b act=%b we=%b want wr_rdy=%b rd_rdy=%b",
                 k, bus.wr_rdy, bus.rd_rdy, bus.ary_read_act, bus.ary_write_enable, !exp_rd, exp_rd);
      end
      tick();
    end
    idle_inputs();
    bus.rd_val = 1'b1; bus.rd_addr = 9'd5; bus.rd_tag = 4'd1;
    tick();
    bus.rd_tag = 4'd2;
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (bus.rsp_val !== 1'b1 || bus.rsp_tag !== 4'd1 || dout[1] !== ones) begin
      n_err++;
      $display("FAIL b2b_first: got val=%b tag=%0d want val=1 tag=1 data ones", bus.rsp_val, bus.rsp_tag);
    end
    tick();
    n_vec++;
    if (bus.rsp_val !== 1'b1 || bus.rsp_tag !== 4'd2) begin
      n_err++;
      $display("FAIL b2b_second: got val=%b tag=%0d want val=1 tag=2", bus.rsp_val, bus.rsp_tag);
    end
    tick();
    n_vec++;
    if (bus.rsp_val !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got val=%b want 0", bus.rsp_val);
    end
    tick();
  endtask

  task automatic test_init_mid();
    int bad;
    bad = 0;
    idle_inputs();
    bus.rd_val = 1'b1; bus.rd_addr = 9'd2; bus.rd_tag = 4'd9;
    #1;
    n_vec++;
    if (bus.rd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL init_mid_rd: got rd_rdy=%b want 1", bus.rd_rdy);
    end
    tick();
    idle_inputs();
    bus.init_req = 1'b1;
    tick();
    bus.wr_val = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.init_req = (i == 9);
      #1;
      if (i == 0) begin
        n_vec++;
        if (bus.rsp_val !== 1'b1 || bus.rsp_tag !== 4'd9) begin
          n_err++;
          $display("FAIL init_mid_rsp: got val=%b tag=%0d want val=1 tag=9", bus.rsp_val, bus.rsp_tag);
        end
      end
      n_vec++;
      if (bus.init_busy !== 1'b1 || bus.wr_rdy !== 1'b0 || bus.ary_addr !== ADDR_W'(i)) begin
        n_err++;
        if (bad < 4)
          $display("FAIL init_mid_sweep: cycle %0d got busy=%b wr_rdy=%b addr=%0d want 1 0 %0d",
                   i, bus.init_busy, bus.wr_rdy, bus.ary_addr, i);
        bad++;
      end
      tick();
    end
    bus.init_req = 1'b0;
    #1;
    n_vec++;
    if (bus.init_busy !== 1'b0 || bus.wr_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL init_mid_end: got busy=%b wr_rdy=%b want 0 1", bus.init_busy, bus.wr_rdy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.rd_val = 1'b1; bus.rd_addr = 9'd3; bus.rd_tag = 4'd5;
    #1;
    n_vec++;
    if (bus.rd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_rd: got rd_rdy=%b want 1", bus.rd_rdy);
    end
    tick();
    idle_inputs();
    #1;
    rst_b = 1'b0;
    #1;
    n_vec++;
    if (bus.rsp_val !== 1'b0 || bus.init_busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_drop: got val=%b busy=%b want 0 1", bus.rsp_val, bus.init_busy);
    end
    tick();
    n_vec++;
    if (bus.rsp_val !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_hold: got val=%b want 0", bus.rsp_val);
    end
    rst_b = 1'b1;
    #1;
    n_vec++;
    if (bus.ary_addr !== 9'd0 || bus.ary_write_enable !== 1'b1 || bus.rsp_val !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_restart0: got addr=%0d we=%b val=%b want 0 1 0", bus.ary_addr, bus.ary_write_enable, bus.rsp_val);
    end
    tick();
    n_vec++;
    if (bus.ary_addr !== 9'd1 || bus.rsp_val !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_restart1: got addr=%0d val=%b want 1 0", bus.ary_addr, bus.rsp_val);
    end
    for (int i = 0; i < 511; i++) tick();
    n_vec++;
    if (bus.init_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_done: got busy=%b want 0", bus.init_busy);
    end
  endtask

  task automatic test_way0();
    idle_inputs();
    bus.wr_val = 1'b1; bus.wr_addr = 9'd7; bus.wr_way = 4'b0010; bus.wr_data = ones;
    tick();
    bus.wr_way = 4'b0000; bus.wr_data = zero;
    #1;
    n_vec++;
    if (bus.wr_rdy !== 1'b1 || bus.ary_write_enable !== 1'b1 || bus.ary_write_way !== 4'b0000) begin
      n_err++;
      $display("FAIL way0_grant: got rdy=%b we=%b way=%b want 1 1 0000",
               bus.wr_rdy, bus.ary_write_enable, bus.ary_write_way);
    end
    tick();
    idle_inputs();
    bus.rd_val = 1'b1; bus.rd_addr = 9'd7; bus.rd_tag = 4'd4;
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (bus.rsp_val !== 1'b1 || bus.rsp_tag !== 4'd4 || dout[1] !== ones || dout[0] !== zero) begin
      n_err++;
      $display("FAIL way0_old_data: got val=%b tag=%0d way1=%h want val=1 tag=4 way1 all ones",
               bus.rsp_val, bus.rsp_tag, dout[1]);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ones  = '1;
    zero  = '0;
    test_reset();
    test_init_sweep();
    test_write_read();
    test_back_to_back();
    test_init_mid();
    test_reset_mid();
    test_way0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tri_512x162_4w_arb.md
TRI_512X162_4W_ARB -- requirements
Module: tri_512x162_4w_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, array index width.
REQ-002 SHALL have parameter DATA_W, default 162, bits per way.
REQ-003 SHALL have parameter WAYS, default 4, way count.
REQ-004 SHALL have parameter STARVE_MAX, default 4, consecutive read denials before forced read grant.
REQ-005 SHALL have ports:
- nclk  in  1  sole clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- init_req  in  1  pulse to start a full-array clear.
- init_busy  out  1  clear sweep in progress.
- wr_val / wr_rdy  in / out  1 / 1  write handshake.
- wr_addr  in  ADDR_W  write index.
- wr_way  in  WAYS  one-hot or multi-hot way select.
- wr_data  in  DATA_W  write data.
- rd_val / rd_rdy  in / out  1 / 1  read handshake.
- rd_addr  in  ADDR_W  read index.
- rd_tag  in  4  requester tag.
- rsp_val  out  1  read data valid at array data_out.
- rsp_tag  out  4  tag of the returning read.
- ary_read_act  out  2  array read enable (both bits equal).
- ary_write_enable  out  1  array write strobe.
- ary_write_way  out  WAYS  array way select.
- ary_addr  out  ADDR_W  array index.
- ary_data_in  out  DATA_W  array write data.

Function
REQ-006 SHALL issue at most one array operation per cycle; all ary_* outputs SHALL be combinational from the state and the current grant.
REQ-007 SHALL implement FSM states INIT, RUN; reset enters INIT with the sweep counter at 0.
REQ-008 In INIT: each cycle SHALL drive ary_write_enable=1, ary_write_way=all ones, ary_addr=counter, ary_data_in=0, then increment the counter; after index 2^ADDR_W-1 the FSM SHALL go to RUN (sweep = 512 cycles at default).
REQ-009 init_busy SHALL be 1 exactly while in INIT; wr_rdy=rd_rdy=0 in INIT.
REQ-010 init_req in RUN SHALL enter INIT next cycle with the counter cleared; init_req in INIT SHALL be ignored (no restart).
REQ-011 In RUN, priority SHALL be write over read, except when the starve counter equals STARVE_MAX, when read wins.
REQ-012 Starve counter: SHALL increment when rd_val=1 and the read is not granted, clear on read grant or rd_val=0, and saturate at STARVE_MAX.
REQ-013 wr_rdy/rd_rdy SHALL be the grant; both SHALL be independent of their own valid, and each SHALL be 1 only if that port wins when both are valid.
REQ-014 Write grant SHALL drive ary_write_enable=1, ary_write_way=wr_way, ary_addr=wr_addr, ary_data_in=wr_data, and ary_read_act=00.
REQ-015 A write with wr_way=0 SHALL be accepted and consume the slot with no array update.
REQ-016 Read grant SHALL drive ary_read_act=11, ary_addr=rd_addr, and ary_write_enable=0.
REQ-017 A read accepted in cycle N SHALL give rsp_val=1 and rsp_tag=rd_tag in cycle N+2, matching the RAM stage plus data_out latch; back-to-back reads SHALL give back-to-back responses.
REQ-018 Reads accepted before an init_req SHALL still return their responses during INIT.
REQ-019 A read in cycle N+1 SHALL observe a write granted in cycle N.

Reset
REQ-020 On rst_b=0, asynchronously: FSM=INIT, sweep counter=0, starve counter=0, response pipeline valids=0, and rsp_tag=0.
REQ-021 During reset: wr_rdy=rd_rdy=0, ary_read_act=00, ary_write_enable=0, init_busy=1, rsp_val=0.
REQ-022 Reset in mid-operation SHALL drop in-flight read responses and restart the sweep from index 0.

Structure
REQ-023 Shared package: the FSM state enum, the read latency constant (2), and the tag width (4).
REQ-024 One sub-module, tri_512x162_4w_rsp_pipe: a 2-stage valid/tag delay line with async reset.

Verification
REQ-025 Release reset -> init_busy=1 for 512 cycles; ary_addr walks 0..511 with ary_write_way=1111 and data 0; then rd_rdy=1.
REQ-026 Write addr 5, way 0010, data all ones, in cycle N; read addr 5, tag 3, in cycle N+1 -> rsp_val and rsp_tag=3 in cycle N+3.
REQ-027 Hold wr_val=1 and rd_val=1 continuously -> grant pattern is 4 writes then 1 read, repeating; the starve counter never exceeds 4.
REQ-028 Issue init_req in cycle N, with a read accepted in cycle N-1 -> the response arrives in N+1; wr_rdy=0 from N+1 for 512 cycles; a second init_req at N+10 does not extend the sweep.
REQ-029 Pull rst_b low one cycle after a read is accepted -> no rsp_val; the sweep restarts at ary_addr=0.
REQ-030 Write with wr_way=0000 -> wr_rdy=1, ary_write_enable=1, ary_write_way=0000; a later read of that index returns the old contents.
